// File: rtl/prog_loader.sv
// prog_loader: program loader and run sequencer for the 8-bit RISC core.
//
// Receives a byte stream from the host over a valid/ready handshake and writes
// it into program memory through the memory's external write port. The core is
// held in reset while loading. Once the last byte is accepted the core is
// released, and the run ends on a halt indication or on a cycle timeout.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start, len            load request pulse and byte count (legal 1..DEPTH)
//   abort                 level, returns to IDLE from any state
//   s_valid/s_data/s_ready host byte stream
//   mem_ewr/mem_ead/mem_edat external memory write port (registered)
//   cpu_rstreq            1 = core held in reset
//   cpu_halt              halt level from the core, sampled in RUN only
//   busy, done, err       status (err is sticky until the next legal start)
module prog_loader #(
    parameter int AW  = 5,
    parameter int DW  = 8,
    parameter int TMO = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mem_ewr,
    output logic [AW-1:0] mem_ead,
    output logic [DW-1:0] mem_edat,
    output logic          cpu_rstreq,
    input  logic          cpu_halt,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      state, nxt;
    logic [AW:0] addr, addr_nxt;
    logic [AW:0] len_q, len_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic        err_nxt;
    logic        len_ok;
    logic        accept;

    assign len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));
    // abort outranks a simultaneous handshake: that byte is not written
    assign accept = s_valid && s_ready && (state == LOAD) && !abort;

    always_comb begin
        nxt      = state;
        addr_nxt = addr;
        len_nxt  = len_q;
        cnt_nxt  = cnt;
        err_nxt  = err;
        if (abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            nxt      = LOAD;
                            len_nxt  = len;
                            addr_nxt = '0;
                            err_nxt  = 1'b0;
                        end else begin
                            nxt     = IDLE;
                            err_nxt = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        addr_nxt = addr + (AW+1)'(1);
                        if (addr == len_q - (AW+1)'(1)) begin
                            nxt     = RUN;
                            cnt_nxt = '0;
                        end
                    end
                end
                RUN: begin
                    // halt is checked first so it wins a tie with the timeout
                    if (cpu_halt) begin
                        nxt = DONE;
                    end else if (cnt == 10'(TMO)) begin
                        nxt     = DONE;
                        err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with
    // the state register (start in N -> s_ready in N+1, last accept in N ->
    // cpu_rstreq low in N+1, alongside that byte's write strobe).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= '0;
            len_q      <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_rstreq <= 1'b1;
            mem_ewr    <= 1'b0;
            mem_ead    <= '0;
            mem_edat   <= '0;
        end else begin
            state      <= nxt;
            addr       <= addr_nxt;
            len_q      <= len_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
            s_ready    <= (nxt == LOAD);
            busy       <= (nxt == LOAD) || (nxt == RUN);
            done       <= (nxt == DONE);
            cpu_rstreq <= (nxt != RUN);
            mem_ewr    <= accept;
            if (accept) begin
                mem_ead  <= addr[AW-1:0];
                mem_edat <= s_data;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: host stimulus pushes expected memory writes into a
// scoreboard queue; a negedge monitor pops and compares every write strobe.
module tb_prog_loader;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int TMO   = 1023;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          cpu_halt = 1'b0;
    logic          s_ready, mem_ewr, cpu_rstreq, busy, done, err;
    logic [AW-1:0] mem_ead;
    logic [DW-1:0] mem_edat;

    always #5 clk = ~clk;

    prog_loader #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_ewr(mem_ewr), .mem_ead(mem_ead), .mem_edat(mem_edat),
        .cpu_rstreq(cpu_rstreq), .cpu_halt(cpu_halt),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && mem_ewr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", mem_ead, mem_edat);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_ead), 32'(e.a));
                chk("wr_data", 32'(mem_edat), 32'(e.d));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        bit legal;
        logic [31:0] lv;
        legal = (l >= 1) && (l <= DEPTH);
        lv = 32'(l);
        start = 1'b1;
        len   = lv[AW:0];
        tick;
        start = 1'b0;
        chk("start_sready", 32'(s_ready), 32'(legal));
        chk("start_err", 32'(err), 32'(!legal));
        chk("start_busy", 32'(busy), 32'(legal));
        chk("start_done", 32'(done), 0);
        chk("start_rstreq", 32'(cpu_rstreq), 1);
    endtask

    // mode 0: s_valid always high, 1: toggles every other cycle, 2: random
    task automatic send_bytes(input int total, input int nsend, input int mode, input int base);
        int i = 0;
        int guard = 0;
        bit acc;
        logic [DW-1:0] d;
        wr_t w;
        while (i < nsend && guard < 1000) begin
            s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            d = (base >= 0) ? DW'(base + i) : DW'($urandom);
            s_data = d;
            acc = s_valid && s_ready;
            if (acc) begin
                w.a = AW'(i);
                w.d = d;
                exp_q.push_back(w);
            end
            tick;
            guard++;
            if (acc) begin
                i++;
                chk("wr_strobe_next_cycle", 32'(mem_ewr), 1);
            end else begin
                chk("no_wr_without_accept", 32'(mem_ewr), 0);
            end
            chk("ready_track", 32'(s_ready), 32'(i < total));
            chk("rstreq_track", 32'(cpu_rstreq), 32'(i < total));
        end
        s_valid = 1'b0;
        if (i < nsend) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sent %0d, expected %0d", i, nsend);
        end
    endtask

    // called in the first RUN cycle; raises halt in run cycle 'at' (at <= TMO)
    task automatic run_halt(input int at);
        bit early = 1'b0;
        for (int k = 0; k < at; k++) begin
            tick;
            if (done) early = 1'b1;
        end
        chk("run_no_early_done", 32'(early), 0);
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0;
        chk("halt_done", 32'(done), 1);
        chk("halt_err", 32'(err), 0);
        chk("halt_rstreq", 32'(cpu_rstreq), 1);
        chk("halt_busy", 32'(busy), 0);
    endtask

    task automatic run_timeout;
        int k = 0;
        while (!done && k < 3000) begin
            tick;
            k++;
        end
        chk("tmo_cycles", 32'(k), 32'(TMO + 1));
        chk("tmo_err", 32'(err), 1);
        chk("tmo_rstreq", 32'(cpu_rstreq), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sready"}, 32'(s_ready), 0);
        chk({tag, "_ewr"}, 32'(mem_ewr), 0);
        chk({tag, "_ead"}, 32'(mem_ead), 0);
        chk({tag, "_edat"}, 32'(mem_edat), 0);
        chk({tag, "_rstreq"}, 32'(cpu_rstreq), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #10;
        chk_reset_vals("reset");
        @(negedge clk) rst = 1'b1;
        tick;

        // four bytes A0..A3 back to back
        do_start(4);
        send_bytes(4, 4, 0, 8'hA0);
        chk("t1_rstreq_low", 32'(cpu_rstreq), 0);
        chk("t1_last_write", 32'(mem_ead), 3);
        run_halt(5);

        // full depth with gapped valid, started from DONE
        do_start(32);
        send_bytes(32, 32, 1, -1);
        run_halt(50);
        repeat (3) tick;
        chk("t2_all_writes_seen", 32'(exp_q.size()), 0);

        // illegal lengths
        do_start(0);
        do_start(33);
        repeat (3) tick;
        chk("t3_still_idle", 32'(busy), 0);

        // timeout, then halt coinciding with the timeout
        do_start(2);
        send_bytes(2, 2, 2, -1);
        run_timeout;
        do_start(2);
        send_bytes(2, 2, 0, -1);
        run_halt(TMO);

        // abort after 3 of 8
        do_start(8);
        send_bytes(8, 3, 0, -1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sready", 32'(s_ready), 0);
        chk("abort_rstreq", 32'(cpu_rstreq), 1);
        chk("abort_err", 32'(err), 0);
        chk("abort_done", 32'(done), 0);
        s_valid = 1'b1;
        repeat (3) tick;
        s_valid = 1'b0;
        chk("abort_drained", 32'(exp_q.size()), 0);
        do_start(2);
        send_bytes(2, 2, 0, 8'h55);
        run_halt(3);

        // async reset mid-load
        do_start(6);
        send_bytes(6, 3, 0, -1);
        tick;
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        chk("async_rst_queue", 32'(exp_q.size()), 0);
        @(negedge clk) rst = 1'b1;
        tick;
        do_start(3);
        send_bytes(3, 3, 2, -1);
        run_halt(10);

        // randomized loads
        for (int r = 0; r < 6; r++) begin
            int l;
            l = $urandom_range(1, DEPTH);
            do_start(l);
            send_bytes(l, l, 2, -1);
            run_halt($urandom_range(0, 200));
        end
        repeat (3) tick;
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
